// File: rtl/sha256_pkg.sv
// sha256_pkg: SHA-256 constants, FSM state type and round/schedule helper functions.
package sha256_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FINAL} state_t;
  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction
  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction
  function automatic logic [31:0] big_s0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic logic [31:0] big_s1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction
  function automatic logic [31:0] small_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] small_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction
  function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
    return r;
  endfunction
endpackage

// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched: 16-word message window, expanded and slid R words per advance.
module sha256_msg_sched import sha256_pkg::*; #(
  parameter int R = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            adv_i,
  input  logic [511:0]    blk_i,
  output logic [32*R-1:0] w_o
);
  logic [31:0] w_q [16];
  logic [31:0] w_d [16];
  logic [31:0] ext [16+R];
  always_comb begin
    for (int i = 0; i < 16; i++) ext[i] = w_q[i];
    for (int j = 0; j < R; j++) ext[16+j] = small_s1(ext[14+j]) + ext[9+j] + small_s0(ext[1+j]) + ext[j];
    for (int i = 0; i < R; i++) w_o[32*i +: 32] = ext[i];
    for (int i = 0; i < 16; i++) w_d[i] = load_i ? blk_i[511-32*i -: 32] : adv_i ? ext[i+R] : w_q[i];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < 16; i++) w_q[i] <= '0;
    else for (int i = 0; i < 16; i++) w_q[i] <= w_d[i];
endmodule

// File: rtl/sha256_round.sv
// sha256_round: one combinational SHA-256 round on packed working state {a..h}, a in the top word.
module sha256_round import sha256_pkg::*; (
  input  logic [255:0] st_i,
  input  logic [31:0]  k_i,
  input  logic [31:0]  w_i,
  output logic [255:0] st_o
);
  logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
  assign {a, b, c, d, e, f, g, h} = st_i;
  assign t1 = h + big_s1(e) + ch(e, f, g) + k_i + w_i;
  assign t2 = big_s0(a) + maj(a, b, c);
  assign st_o = {t1 + t2, a, b, c, d + t1, e, f, g};
endmodule

// File: rtl/sha256_compress_iter.sv
// sha256_compress_iter: iterative SHA-256 compression, ROUNDS_PER_CYCLE rounds per clock, chained H state.
module sha256_compress_iter import sha256_pkg::*; #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int CNT_W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         blk_valid_i,
  output logic         blk_ready_o,
  input  logic         blk_first_i,
  input  logic [511:0] blk_data_i,
  output logic         busy_o,
  output logic         digest_valid_o,
  output logic [255:0] digest_o
);
  localparam int R = ROUNDS_PER_CYCLE;
  if ((R & (R - 1)) != 0 || R < 1 || R > 16) begin : g_bad_r
    $error("ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end
  if (CNT_W < 7) begin : g_bad_cnt
    $error("CNT_W must hold the value 64");
  end
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [255:0] h_q, h_d, base_q, base_d, wv_q, wv_d, dig_q, dig_d, init, sum, chain;
  logic dv_q, dv_d, xfer;
  logic [32*R-1:0] w;
  assign xfer = blk_valid_i && state_q == IDLE;
  assign init = blk_first_i ? IV : h_q;
  assign sum = add8(base_q, wv_q);
  sha256_msg_sched #(.R(R)) u_sched (
    .clk(clk), .rst_n(rst_n), .load_i(xfer), .adv_i(state_q == RUN), .blk_i(blk_data_i), .w_o(w)
  );
  for (genvar i = 0; i < R; i++) begin : g_r
    logic [255:0] s_in, s_out;
    logic [5:0] kidx;
    assign kidx = cnt_q[5:0] + 6'(i);
    if (i == 0) begin : g_f
      assign s_in = wv_q;
    end else begin : g_n
      assign s_in = g_r[i-1].s_out;
    end
    sha256_round u_round (.st_i(s_in), .k_i(K[kidx]), .w_i(w[32*i +: 32]), .st_o(s_out));
  end
  assign chain = g_r[R-1].s_out;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    wv_d = wv_q;
    base_d = base_q;
    h_d = h_q;
    dig_d = dig_q;
    dv_d = 1'b0;
    if (xfer) begin
      state_d = RUN;
      cnt_d = '0;
      wv_d = init;
      base_d = init;
    end
    if (state_q == RUN) begin
      wv_d = chain;
      cnt_d = cnt_q + CNT_W'(R);
      state_d = (cnt_q + CNT_W'(R) == CNT_W'(64)) ? FINAL : RUN;
    end
    if (state_q == FINAL) begin
      h_d = sum;
      dig_d = sum;
      dv_d = 1'b1;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      h_q <= IV;
      base_q <= '0;
      wv_q <= '0;
      dig_q <= '0;
      dv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      h_q <= h_d;
      base_q <= base_d;
      wv_q <= wv_d;
      dig_q <= dig_d;
      dv_q <= dv_d;
    end
  assign blk_ready_o = state_q == IDLE;
  assign busy_o = state_q != IDLE;
  assign digest_valid_o = dv_q;
  assign digest_o = dig_q;
endmodule
